// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port integer register file.
// x0 is hardwired to zero. Same-edge writes bypass to reads (write-first).
// A per-register busy scoreboard is set by reservations from issue and
// cleared by writeback. Every output comes straight from a register.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*AW-1:0]     rd_addr,
    input  logic [NRD-1:0]        rd_valid,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_ack,
    output logic [NRD-1:0]        rd_busy,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ack,
    input  logic [AW-1:0]         rsv_addr,
    input  logic                  rsv_valid,
    output logic [NREGS-1:0]      busy_vec
);

    // Architectural state. Entry 0 is never loaded, so it stays zero.
    logic [XLEN-1:0]     regs_q [NREGS];
    logic [XLEN-1:0]     regs_d [NREGS];
    logic [NREGS-1:0]    busy_q;
    logic [NREGS-1:0]    busy_d;

    // Read and write response registers.
    logic [NRD*XLEN-1:0] rd_data_q;
    logic [NRD*XLEN-1:0] rd_data_d;
    logic [NRD-1:0]      rd_ack_q;
    logic [NRD-1:0]      rd_ack_d;
    logic [NRD-1:0]      rd_busy_q;
    logic [NRD-1:0]      rd_busy_d;
    logic                wr_ack_q;
    logic                wr_ack_d;

    // Decoded request qualifiers.
    logic [AW-1:0]       ra_s [NRD];
    logic                wr_nz_s;
    logic                rsv_nz_s;

    // A write or reservation of x0 has no effect on state.
    assign wr_nz_s  = wr_valid  & (wr_addr  != {AW{1'b0}});
    assign rsv_nz_s = rsv_valid & (rsv_addr != {AW{1'b0}});

    // Unpack the per-port read addresses.
    for (genvar g = 0; g < NRD; g++) begin : g_ra
        assign ra_s[g] = rd_addr[g*AW +: AW];
    end

    // Next register contents: load the write target and keep x0 at zero.
    always_comb begin
        for (int n = 0; n < NREGS; n++) begin
            if (n == 0) begin
                regs_d[n] = {XLEN{1'b0}};
            end else if (wr_nz_s && (wr_addr == AW'(n))) begin
                regs_d[n] = wr_data;
            end else begin
                regs_d[n] = regs_q[n];
            end
        end
    end

    // Next scoreboard. A same-edge reservation beats writeback because the
    // reservation belongs to a younger instruction.
    always_comb begin
        for (int n = 0; n < NREGS; n++) begin
            if (n == 0) begin
                busy_d[n] = 1'b0;
            end else if (rsv_nz_s && (rsv_addr == AW'(n))) begin
                busy_d[n] = 1'b1;
            end else if (wr_valid && (wr_addr == AW'(n))) begin
                busy_d[n] = 1'b0;
            end else begin
                busy_d[n] = busy_q[n];
            end
        end
    end

    // Per-port read response: bypass a same-edge write to a nonzero address.
    // A same-edge write clears rd_busy. A same-edge reservation does not set it.
    always_comb begin
        rd_data_d = rd_data_q;
        rd_ack_d  = {NRD{1'b0}};
        rd_busy_d = {NRD{1'b0}};
        for (int i = 0; i < NRD; i++) begin
            if (rd_valid[i]) begin
                rd_ack_d[i] = 1'b1;
                if (wr_nz_s && (wr_addr == ra_s[i])) begin
                    rd_data_d[i*XLEN +: XLEN] = wr_data;
                end else if (ra_s[i] == {AW{1'b0}}) begin
                    rd_data_d[i*XLEN +: XLEN] = {XLEN{1'b0}};
                end else begin
                    rd_data_d[i*XLEN +: XLEN] = regs_q[ra_s[i]];
                end
                if (wr_valid && (wr_addr == ra_s[i])) begin
                    rd_busy_d[i] = 1'b0;
                end else begin
                    rd_busy_d[i] = busy_q[ra_s[i]];
                end
            end else begin
                rd_ack_d[i]               = 1'b0;
                rd_busy_d[i]              = 1'b0;
                rd_data_d[i*XLEN +: XLEN] = rd_data_q[i*XLEN +: XLEN];
            end
        end
    end

    // Every accepted write, including a write to x0, is acknowledged one cycle later.
    always_comb begin
        if (wr_valid) begin
            wr_ack_d = 1'b1;
        end else begin
            wr_ack_d = 1'b0;
        end
    end

    // Register file storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= {XLEN{1'b0}};
            end
        end else begin
            for (int n = 0; n < NREGS; n++) begin
                regs_q[n] <= regs_d[n];
            end
        end
    end

    // Scoreboard and response registers. Reset discards all in-flight acks.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= {NREGS{1'b0}};
            rd_data_q <= {(NRD*XLEN){1'b0}};
            rd_ack_q  <= {NRD{1'b0}};
            rd_busy_q <= {NRD{1'b0}};
            wr_ack_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_ack_d;
            rd_busy_q <= rd_busy_d;
            wr_ack_q  <= wr_ack_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_ack   = rd_ack_q;
    assign rd_busy  = rd_busy_q;
    assign wr_ack   = wr_ack_q;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. It drives two configurations with the same stimulus:
// dut_a uses the default geometry (32-bit, 32 regs, 2 ports).
// dut_b uses 64-bit, 16 regs and 3 ports.
// Stimulus comes from a vector table plus a few hand-written sequences.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;
    logic wr_valid;
    logic rsv_valid;

    // Configuration A: XLEN=32, NREGS=32, NRD=2 (AW=5).
    logic [9:0]   a_rd_addr;
    logic [1:0]   a_rd_valid;
    logic [63:0]  a_rd_data;
    logic [1:0]   a_rd_ack;
    logic [1:0]   a_rd_busy;
    logic [4:0]   a_wr_addr;
    logic [31:0]  a_wr_data;
    logic         a_wr_ack;
    logic [4:0]   a_rsv_addr;
    logic [31:0]  a_busy_vec;

    // Configuration B: XLEN=64, NREGS=16, NRD=3 (AW=4).
    logic [11:0]  b_rd_addr;
    logic [2:0]   b_rd_valid;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_ack;
    logic [2:0]   b_rd_busy;
    logic [3:0]   b_wr_addr;
    logic [63:0]  b_wr_data;
    logic         b_wr_ack;
    logic [3:0]   b_rsv_addr;
    logic [15:0]  b_busy_vec;

    int checks = 0;
    int errors = 0;

    regfile_mp dut_a (
        .clk(clk), .reset(reset),
        .rd_addr(a_rd_addr), .rd_valid(a_rd_valid), .rd_data(a_rd_data),
        .rd_ack(a_rd_ack), .rd_busy(a_rd_busy),
        .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_valid(wr_valid), .wr_ack(a_wr_ack),
        .rsv_addr(a_rsv_addr), .rsv_valid(rsv_valid), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(3)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr(b_rd_addr), .rd_valid(b_rd_valid), .rd_data(b_rd_data),
        .rd_ack(b_rd_ack), .rd_busy(b_rd_busy),
        .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_valid(wr_valid), .wr_ack(b_wr_ack),
        .rsv_addr(b_rsv_addr), .rsv_valid(rsv_valid), .busy_vec(b_busy_vec)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [2:0]  rv;
        logic [3:0]  ra0, ra1, ra2;
        logic        wv;
        logic [3:0]  wa;
        logic [63:0] wd;
        logic        sv;
        logic [3:0]  sa;
        logic [2:0]  e_ack;
        logic [2:0]  e_busy;
        logic        e_wack;
        logic [15:0] e_bv;
        logic [63:0] e_d0, e_d1, e_d2;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic add(input string nm, input logic rst, input logic [2:0] rv,
                       input logic [3:0] ra0, input logic [3:0] ra1, input logic [3:0] ra2,
                       input logic wv, input logic [3:0] wa, input logic [63:0] wd,
                       input logic sv, input logic [3:0] sa,
                       input logic [2:0] e_ack, input logic [2:0] e_busy, input logic e_wack,
                       input logic [15:0] e_bv,
                       input logic [63:0] e_d0, input logic [63:0] e_d1, input logic [63:0] e_d2);
        vec_t v;
        v.name = nm; v.rst = rst; v.rv = rv; v.ra0 = ra0; v.ra1 = ra1; v.ra2 = ra2;
        v.wv = wv; v.wa = wa; v.wd = wd; v.sv = sv; v.sa = sa;
        v.e_ack = e_ack; v.e_busy = e_busy; v.e_wack = e_wack; v.e_bv = e_bv;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_d2 = e_d2;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset      = v.rst;
        wr_valid   = v.wv;
        rsv_valid  = v.sv;
        a_rd_valid = v.rv[1:0];
        a_rd_addr  = {1'b0, v.ra1, 1'b0, v.ra0};
        a_wr_addr  = {1'b0, v.wa};
        a_wr_data  = v.wd[31:0];
        a_rsv_addr = {1'b0, v.sa};
        b_rd_valid = v.rv;
        b_rd_addr  = {v.ra2, v.ra1, v.ra0};
        b_wr_addr  = v.wa;
        b_wr_data  = v.wd;
        b_rsv_addr = v.sa;
    endtask

    task automatic set_idle();
        vec_t v;
        v.rst = 1'b0; v.rv = 3'b000; v.ra0 = 4'd0; v.ra1 = 4'd0; v.ra2 = 4'd0;
        v.wv = 1'b0; v.wa = 4'd0; v.wd = 64'd0; v.sv = 1'b0; v.sa = 4'd0;
        drive(v);
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d %s", idx, v.name);
        chk({t, " A rd_ack"},   64'(a_rd_ack),   64'(v.e_ack[1:0]));
        chk({t, " A rd_busy"},  64'(a_rd_busy),  64'(v.e_busy[1:0]));
        chk({t, " A wr_ack"},   64'(a_wr_ack),   64'(v.e_wack));
        chk({t, " A busy_vec"}, 64'(a_busy_vec), 64'(v.e_bv));
        chk({t, " A rd_data0"}, 64'(a_rd_data[31:0]),  64'(v.e_d0[31:0]));
        chk({t, " A rd_data1"}, 64'(a_rd_data[63:32]), 64'(v.e_d1[31:0]));
        chk({t, " B rd_ack"},   64'(b_rd_ack),   64'(v.e_ack));
        chk({t, " B rd_busy"},  64'(b_rd_busy),  64'(v.e_busy));
        chk({t, " B wr_ack"},   64'(b_wr_ack),   64'(v.e_wack));
        chk({t, " B busy_vec"}, 64'(b_busy_vec), 64'(v.e_bv));
        chk({t, " B rd_data0"}, b_rd_data[63:0],    v.e_d0);
        chk({t, " B rd_data1"}, b_rd_data[127:64],  v.e_d1);
        chk({t, " B rd_data2"}, b_rd_data[191:128], v.e_d2);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] d1, d2, df, w1, w2, w3;
        d1 = 64'hA5A5_5A5A_DEAD_BEEF;
        d2 = 64'h0123_4567_1234_5678;
        df = 64'hFFFF_FFFF_FFFF_FFFF;
        w1 = 64'h1000_0000_0000_0001;
        w2 = 64'h2000_0000_0000_0002;
        w3 = 64'h3000_0000_0000_000A;

        set_idle();
        reset = 1'b1;
        step();

        //  name            rst rv      ra0   ra1   ra2   wv  wa    wd        sv  sa    ack     busy    wack e_bv        d0          d1          d2
        add("reset wins",   1, 3'b111, 4'd4, 4'd4, 4'd4, 1, 4'd4, df,       1, 4'd4, 3'b000, 3'b000, 0, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("read x5 x0",   0, 3'b111, 4'd5, 4'd0, 4'd0, 0, 4'd0, 64'd0,    0, 4'd0, 3'b111, 3'b000, 0, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("write x7",     0, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd7, d1,       0, 4'd0, 3'b000, 3'b000, 1, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("read x7",      0, 3'b111, 4'd7, 4'd7, 4'd7, 0, 4'd0, 64'd0,    0, 4'd0, 3'b111, 3'b000, 0, 16'h0000, d1,         d1,         d1);
        add("bypass x3",    0, 3'b111, 4'd3, 4'd7, 4'd3, 1, 4'd3, d2,       0, 4'd0, 3'b111, 3'b000, 1, 16'h0000, d2,         d1,         d2);
        add("reread x3",    0, 3'b111, 4'd3, 4'd3, 4'd3, 0, 4'd0, 64'd0,    0, 4'd0, 3'b111, 3'b000, 0, 16'h0000, d2,         d2,         d2);
        add("write x0",     0, 3'b111, 4'd0, 4'd0, 4'd0, 1, 4'd0, df,       0, 4'd0, 3'b111, 3'b000, 1, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("read x0",      0, 3'b001, 4'd0, 4'd0, 4'd0, 0, 4'd0, 64'd0,    0, 4'd0, 3'b001, 3'b000, 0, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("reserve x9",   0, 3'b000, 4'd0, 4'd0, 4'd0, 0, 4'd0, 64'd0,    1, 4'd9, 3'b000, 3'b000, 0, 16'h0200, 64'd0,      64'd0,      64'd0);
        add("read busy x9", 0, 3'b111, 4'd9, 4'd7, 4'd9, 0, 4'd0, 64'd0,    0, 4'd0, 3'b111, 3'b101, 0, 16'h0200, 64'd0,      d1,         64'd0);
        add("wb x9 + read", 0, 3'b111, 4'd9, 4'd9, 4'd3, 1, 4'd9, 64'h55,   0, 4'd0, 3'b111, 3'b000, 1, 16'h0000, 64'h55,     64'h55,     d2);
        add("rsv+wr x9",    0, 3'b001, 4'd9, 4'd0, 4'd0, 1, 4'd9, 64'h77,   1, 4'd9, 3'b001, 3'b000, 1, 16'h0200, 64'h77,     64'h55,     d2);
        add("rsv x4 + rd",  0, 3'b011, 4'd9, 4'd4, 4'd0, 0, 4'd0, 64'd0,    1, 4'd4, 3'b011, 3'b001, 0, 16'h0210, 64'h77,     64'd0,      d2);
        add("wb x4 rsv x0", 0, 3'b011, 4'd9, 4'd4, 4'd0, 1, 4'd4, 64'hC0FFEE, 1, 4'd0, 3'b011, 3'b001, 1, 16'h0200, 64'h77,   64'hC0FFEE, d2);
        add("wr idle x5",   0, 3'b000, 4'd0, 4'd0, 4'd0, 1, 4'd5, 64'h1111, 0, 4'd0, 3'b000, 3'b000, 1, 16'h0200, 64'h77,     64'hC0FFEE, d2);
        add("read x5 p2",   0, 3'b100, 4'd0, 4'd0, 4'd5, 0, 4'd0, 64'd0,    0, 4'd0, 3'b100, 3'b000, 0, 16'h0200, 64'h77,     64'hC0FFEE, 64'h1111);
        add("reset midop",  1, 3'b111, 4'd4, 4'd4, 4'd4, 1, 4'd4, df,       1, 4'd9, 3'b000, 3'b000, 0, 16'h0000, 64'd0,      64'd0,      64'd0);
        add("read after rst",0,3'b111, 4'd4, 4'd7, 4'd9, 0, 4'd0, 64'd0,    0, 4'd0, 3'b111, 3'b000, 0, 16'h0000, 64'd0,      64'd0,      64'd0);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            step();
            check_vec(vq[i], i);
        end

        // Back-to-back writes keep wr_ack high on every cycle.
        @(negedge clk);
        set_idle();
        wr_valid = 1'b1; a_wr_addr = 5'd1; b_wr_addr = 4'd1; a_wr_data = w1[31:0]; b_wr_data = w1;
        step();
        chk("b2b wack1 A", 64'(a_wr_ack), 64'd1);
        chk("b2b wack1 B", 64'(b_wr_ack), 64'd1);
        @(negedge clk);
        a_wr_addr = 5'd2; b_wr_addr = 4'd2; a_wr_data = w2[31:0]; b_wr_data = w2;
        step();
        chk("b2b wack2 A", 64'(a_wr_ack), 64'd1);
        chk("b2b wack2 B", 64'(b_wr_ack), 64'd1);
        @(negedge clk);
        a_wr_addr = 5'd10; b_wr_addr = 4'd10; a_wr_data = w3[31:0]; b_wr_data = w3;
        step();
        chk("b2b wack3 A", 64'(a_wr_ack), 64'd1);
        chk("b2b wack3 B", 64'(b_wr_ack), 64'd1);
        @(negedge clk);
        set_idle();
        step();
        chk("b2b wack off A", 64'(a_wr_ack), 64'd0);
        chk("b2b wack off B", 64'(b_wr_ack), 64'd0);

        // Read back the three writes on all ports.
        @(negedge clk);
        a_rd_valid = 2'b11; a_rd_addr = {5'd2, 5'd1};
        b_rd_valid = 3'b111; b_rd_addr = {4'd10, 4'd2, 4'd1};
        step();
        chk("b2b rd0 A", 64'(a_rd_data[31:0]),  64'(w1[31:0]));
        chk("b2b rd1 A", 64'(a_rd_data[63:32]), 64'(w2[31:0]));
        chk("b2b rd0 B", b_rd_data[63:0],    w1);
        chk("b2b rd1 B", b_rd_data[127:64],  w2);
        chk("b2b rd2 B", b_rd_data[191:128], w3);

        // Reset while reads are still in flight drops the acks and clears the data.
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst inflight ack A",  64'(a_rd_ack), 64'd0);
        chk("rst inflight ack B",  64'(b_rd_ack), 64'd0);
        chk("rst inflight data A", a_rd_data, 64'd0);
        chk("rst inflight data B", b_rd_data[63:0], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("post rst rd0 A", 64'(a_rd_data[31:0]), 64'd0);
        chk("post rst rd2 B", b_rd_data[191:128],   64'd0);
        chk("post rst ack B", 64'(b_rd_ack), 64'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the current 2-read/1-write regfile in the RISC-V core.
- Adds configurable width, depth and read-port count, a hardwired-zero x0, write-to-read bypass and a per-register busy scoreboard.
- Decode/issue reserves destination registers. Writeback clears them. Operand reads return data plus a busy flag so issue can stall on RAW hazards.

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of independent read ports, 1..4.
- AW, $clog2(NREGS), register address width; derived, never overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_valid  in  NRD  per-port read request.
- rd_data  out  NRD*XLEN  registered read data; port i occupies bits [i*XLEN +: XLEN].
- rd_ack  out  NRD  per-port read acknowledge; rd_data and rd_busy are valid while high.
- rd_busy  out  NRD  per-port: the register read had a pending reservation.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- wr_valid  in  1  write request.
- wr_ack  out  1  write acknowledge.
- rsv_addr  in  AW  destination register to reserve.
- rsv_valid  in  1  reservation request.
- busy_vec  out  NREGS  current scoreboard; bit n set means register n has a pending write.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset values: all registers 0, busy_vec 0, rd_ack 0, rd_data 0, rd_busy 0, wr_ack 0.
  - Reset wins over every concurrent request.
  - Reset mid-operation discards in-flight acks on the next edge.
- Register 0: always reads 0. Writes to 0 are discarded but still acknowledged. Reservations of 0 are ignored; busy_vec[0] is constant 0.
- Write path:
  - Edge with wr_valid=1: registers[wr_addr] <= wr_data (if addr != 0), busy[wr_addr] cleared, wr_ack <= 1.
  - Edge with wr_valid=0: wr_ack <= 0.
  - wr_ack is high the cycle after each accepted write; back-to-back writes give continuous wr_ack.
- Read path, per port i, independent of the others:
  - Latency is 1 cycle. Edge with rd_valid[i]=1: rd_ack[i] <= 1 and rd_data[i] <= value.
  - value is wr_data if wr_valid=1 and wr_addr == rd_addr[i] != 0 on that edge (write-first bypass).
  - Otherwise value is registers[rd_addr[i]], with 0 returned for address 0.
  - On the same edge, rd_busy[i] <= busy[rd_addr[i]]. If a same-edge write to that address clears the busy bit, rd_busy[i] <= 0.
  - A same-edge reservation does not affect rd_busy of that read.
  - Edge with rd_valid[i]=0: rd_ack[i] <= 0, rd_busy[i] <= 0, rd_data[i] holds its previous value.
  - Multiple ports may read the same address on the same edge; all return identical data.
- Scoreboard:
  - rsv_valid=1 with rsv_addr != 0 sets busy[rsv_addr] on the edge.
  - A write to the same address on the same edge: set wins, since the reservation belongs to a younger instruction.
  - A write to a register that is not busy is legal and leaves it not busy.
- No simulation-only $display output in synthesised paths.

Test Plan:
- Reset, then read x5 on port 0 and x0 on port 1 -> one cycle later rd_ack=2'b11, both rd_data=0, rd_busy=2'b00, busy_vec=0.
- Write x7=32'hDEADBEEF, next cycle read x7 on both ports -> wr_ack=1 the cycle after the write; read returns 32'hDEADBEEF on both ports with rd_ack=2'b11.
- Same edge: write x3=32'h12345678 and read x3 on port 0 -> rd_data[0]=32'h12345678 one cycle later (bypass); a following read also returns 32'h12345678.
- Write x0=32'hFFFFFFFF, then read x0 -> wr_ack=1, read returns 0, busy_vec[0]=0.
- Reserve x9 -> busy_vec[9]=1; read x9 -> rd_busy=1.
  - Then write x9=32'h55 with a concurrent read of x9 -> rd_data=32'h55, rd_busy=0, busy_vec[9]=0.
  - Then reserve and write x9 on the same edge -> busy_vec[9]=1.
- Assert reset while rd_valid=1 and wr_valid=1 on x4 -> all acks 0, x4 reads 0 after reset, busy_vec=0.
- Repeat all of the above with NRD=3, XLEN=64, NREGS=16.
